// File: rtl/systolic_tile_engine.sv
// systolic_tile_engine: output-stationary N_ROWS x N_COLS signed MAC tile with
// built-in operand skew, start/busy/done command handshake, valid/ready slice
// streaming and row-by-row valid/ready result readout.
module systolic_tile_engine #(
  parameter int unsigned N_ROWS = 4,
  parameter int unsigned N_COLS = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned SAT    = 0,
  parameter int unsigned K_MAX  = 256
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           start,
  input  logic [$clog2(K_MAX+1)-1:0]                     k_len,
  output logic                                           busy,
  output logic                                           done,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [N_ROWS*DATA_W-1:0]                       a_in_flat,
  input  logic [N_COLS*DATA_W-1:0]                       b_in_flat,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [N_COLS*ACC_W-1:0]                        out_row,
  output logic [((N_ROWS > 1) ? $clog2(N_ROWS) : 1)-1:0] out_row_idx
);

  localparam int unsigned KW         = $clog2(K_MAX + 1);
  localparam int unsigned RW         = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned DW         = $clog2(N_ROWS + N_COLS);
  localparam int unsigned PW         = 2 * DATA_W;
  localparam int unsigned SW         = ACC_W + 1;
  localparam int unsigned DRAIN_LAST = N_ROWS + N_COLS - 2;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  state_t                    state, state_d;
  logic [KW-1:0]             beat, beat_d;
  logic [KW-1:0]             k_q, k_d;
  logic [DW-1:0]             dcnt, dcnt_d;
  logic [RW-1:0]             idx_d;
  logic                      busy_d, done_d, in_ready_d, out_valid_d;
  logic [N_COLS*ACC_W-1:0]   out_row_d;

  logic                      clr, adv, feed_en;

  logic signed [DATA_W-1:0]  a_feed [N_ROWS];
  logic signed [DATA_W-1:0]  b_feed [N_COLS];
  logic signed [DATA_W-1:0]  a_sr   [N_ROWS][N_ROWS];
  logic signed [DATA_W-1:0]  b_sr   [N_COLS][N_COLS];
  logic signed [DATA_W-1:0]  a_sk   [N_ROWS];
  logic signed [DATA_W-1:0]  b_sk   [N_COLS];
  logic signed [DATA_W-1:0]  a_reg  [N_ROWS][N_COLS];
  logic signed [DATA_W-1:0]  b_reg  [N_ROWS][N_COLS];
  logic signed [DATA_W-1:0]  a_in   [N_ROWS][N_COLS];
  logic signed [DATA_W-1:0]  b_in   [N_ROWS][N_COLS];
  logic signed [ACC_W-1:0]   acc    [N_ROWS][N_COLS];

  // One MAC step: full-precision product, optional clamp on signed overflow.
  function automatic logic signed [ACC_W-1:0] mac(
    input logic signed [ACC_W-1:0]  acc_q,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] sum;
    prod = PW'(a) * PW'(b);
    sum  = SW'(acc_q) + SW'(prod);
    if ((SAT != 0) && (sum[SW-1] != sum[SW-2])) begin
      mac = sum[SW-1] ? ACC_MIN : ACC_MAX;
    end else begin
      mac = sum[ACC_W-1:0];
    end
  endfunction

  assign clr     = (state == IDLE) && start;
  assign adv     = (state == LOAD) || (state == DRAIN);
  assign feed_en = (state == LOAD) && in_valid;

  // Operand injection: accepted slice in LOAD, zeros otherwise (bubbles, drain).
  always_comb begin
    for (int r = 0; r < N_ROWS; r++) begin
      a_feed[r] = feed_en ? a_in_flat[r*DATA_W +: DATA_W] : '0;
    end
    for (int c = 0; c < N_COLS; c++) begin
      b_feed[c] = feed_en ? b_in_flat[c*DATA_W +: DATA_W] : '0;
    end
  end

  // Skew taps: lane r of A and lane c of B delayed by r and c cycles.
  for (genvar r = 0; r < N_ROWS; r++) begin : g_a_tap
    if (r == 0) begin : g_direct
      assign a_sk[r] = a_feed[r];
    end else begin : g_delay
      assign a_sk[r] = a_sr[r][r-1];
    end
  end

  for (genvar c = 0; c < N_COLS; c++) begin : g_b_tap
    if (c == 0) begin : g_direct
      assign b_sk[c] = b_feed[c];
    end else begin : g_delay
      assign b_sk[c] = b_sr[c][c-1];
    end
  end

  // PE operand routing: A enters from the left edge, B from the top edge.
  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
      if (c == 0) begin : g_a_edge
        assign a_in[r][c] = a_sk[r];
      end else begin : g_a_pass
        assign a_in[r][c] = a_reg[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_in[r][c] = b_sk[c];
      end else begin : g_b_pass
        assign b_in[r][c] = b_reg[r-1][c];
      end
    end
  end

  // Skew chains, PE pass-through registers and accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int s = 0; s < N_ROWS; s++) a_sr[r][s] <= '0;
      end
      for (int c = 0; c < N_COLS; c++) begin
        for (int s = 0; s < N_COLS; s++) b_sr[c][s] <= '0;
      end
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          a_reg[r][c] <= '0;
          b_reg[r][c] <= '0;
          acc[r][c]   <= '0;
        end
      end
    end else if (adv) begin
      for (int r = 0; r < N_ROWS; r++) begin
        a_sr[r][0] <= a_feed[r];
        for (int s = 1; s < N_ROWS; s++) a_sr[r][s] <= a_sr[r][s-1];
      end
      for (int c = 0; c < N_COLS; c++) begin
        b_sr[c][0] <= b_feed[c];
        for (int s = 1; s < N_COLS; s++) b_sr[c][s] <= b_sr[c][s-1];
      end
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          a_reg[r][c] <= a_in[r][c];
          b_reg[r][c] <= b_in[r][c];
          acc[r][c]   <= mac(acc[r][c], a_in[r][c], b_in[r][c]);
        end
      end
    end
  end

  // Sequencer next-state and next-value of every registered output.
  always_comb begin
    state_d   = state;
    beat_d    = beat;
    k_d       = k_q;
    dcnt_d    = dcnt;
    idx_d     = out_row_idx;
    done_d    = 1'b0;
    out_row_d = out_row;

    case (state)
      IDLE: begin
        if (start) begin
          k_d     = k_len;
          beat_d  = '0;
          dcnt_d  = '0;
          idx_d   = '0;
          state_d = (k_len == '0) ? OUT : LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          beat_d = beat + KW'(1);
          if (beat_d == k_q) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end
        end
      end
      DRAIN: begin
        if (dcnt == DW'(DRAIN_LAST)) begin
          state_d = OUT;
        end else begin
          dcnt_d = dcnt + DW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          if (out_row_idx == RW'(N_ROWS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = out_row_idx + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == OUT);

    // Accumulators are cleared on the same edge a zero-length tile enters OUT.
    if (state_d == OUT) begin
      if (state == IDLE) begin
        out_row_d = '0;
      end else begin
        for (int c = 0; c < N_COLS; c++) begin
          out_row_d[c*ACC_W +: ACC_W] = acc[idx_d][c];
        end
      end
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat        <= '0;
      k_q         <= '0;
      dcnt        <= '0;
      out_row_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_row     <= '0;
    end else begin
      state       <= state_d;
      beat        <= beat_d;
      k_q         <= k_d;
      dcnt        <= dcnt_d;
      out_row_idx <= idx_d;
      busy        <= busy_d;
      done        <= done_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      out_row     <= out_row_d;
    end
  end

endmodule

// File: doc/systolic_tile_engine.md
# systolic_tile_engine

Self-sequencing output-stationary systolic MAC tile of N_ROWS x N_COLS signed PEs, generalising the 2x2 `systolic_array` to parametrised size, operand and accumulator width. Adds built-in input skew, a start/busy/done command handshake, valid/ready input streaming with bubble tolerance, optional saturation, and row-by-row valid/ready result readout. It sits between the operand staging buffers and the output writeback path of the accelerator datapath.

## Interface
- N_ROWS, 4, PE rows (A operand lanes)
- N_COLS, 4, PE columns (B operand lanes)
- DATA_W, 8, signed operand width
- ACC_W, 32, signed accumulator width (ACC_W >= 2*DATA_W)
- SAT, 0, 1 = saturating accumulate, 0 = wrap modulo 2^ACC_W
- K_MAX, 256, maximum slices per tile; KW = $clog2(K_MAX+1)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- start  in  1  begin tile; sampled only in IDLE
- k_len  in  KW  slice count, latched on accepted start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after last result row accepted
- in_valid  in  1  slice present on a_in_flat/b_in_flat
- in_ready  out  1  high in LOAD only
- a_in_flat  in  N_ROWS*DATA_W  A slice, lane r at [r*DATA_W +: DATA_W]
- b_in_flat  in  N_COLS*DATA_W  B slice, lane c at [c*DATA_W +: DATA_W]
- out_valid  out  1  result row presented
- out_ready  in  1  consumer accepts row
- out_row  out  N_COLS*ACC_W  C[out_row_idx][c] at [c*ACC_W +: ACC_W]
- out_row_idx  out  $clog2(N_ROWS) (min 1)  row index of out_row

## Operation
- States: IDLE -> LOAD -> DRAIN -> OUT -> IDLE.
- IDLE: start=1 latches k_len, clears all accumulators and skew/PE pipeline registers. k_len>0 -> LOAD; k_len==0 -> OUT directly (all-zero results). start ignored in other states.
- LOAD: in_ready=1. Each in_valid&&in_ready beat accepts slice k; beat counter increments; after beat k_len, go DRAIN. in_valid low injects zero operands (bubble); array advances every cycle regardless. in_valid ignored outside LOAD.
- Skew: A lane r delayed r cycles, B lane c delayed c cycles before entering the array. A passes right, B passes down, one register per PE; slice k meets at PE(r,c) exactly once.
- PE: acc <= acc + a*b, full-precision signed product sign-extended to ACC_W. SAT=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1], clamped value is sticky-correct (further adds from clamp). SAT=0: wrap.
- DRAIN: fixed N_ROWS+N_COLS-1 cycles with zero injection, then OUT.
- OUT: out_valid=1, out_row = accumulators of row out_row_idx starting at 0; advance idx on out_valid&&out_ready. Last row handshake -> IDLE, done=1 in that first IDLE cycle.
- Accumulators hold their values after done until next accepted start.
- Reset (any state, including mid-LOAD/OUT): aborts tile, no done pulse.

## Timing
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_row=0, out_row_idx=0, state IDLE, all accumulators and pipeline registers 0.
- Start accepted at edge E: busy and in_ready high from cycle E+1.
- No bubbles, no backpressure: first out_valid at cycle E + 1 + k_len + N_ROWS + N_COLS - 1; done N_ROWS cycles later.
- out_valid, out_row, out_row_idx stable while out_valid && !out_ready.
- start in the cycle done=1 is accepted (back-to-back tiles).
- k_len > K_MAX not supported; behaviour undefined.

## Test plan
- 2x2, DATA_W=8, k_len=3, all A=1, all B=2 -> rows 0,1 each {6,6}; done single-cycle pulse; busy low after.
- 4x4, k_len=64, random INT8, in_valid low every other cycle -> results equal golden A*B; in_ready high throughout LOAD; exactly 64 beats consumed.
- OUT with out_ready low 3 cycles on row 1 -> out_row/out_row_idx held, no row skipped or repeated, done after row 3 accepted.
- ACC_W=16, a=b=-128, k_len=4: SAT=1 -> every C=32767; SAT=0 -> every C=0.
- k_len=0 -> in_ready never asserted, N_ROWS all-zero rows streamed, done pulses; back-to-back start on done cycle runs next tile correctly.
- rst_n low mid-LOAD -> next cycle all outputs at reset values, no done; subsequent tile with k_len=5 matches golden.
